// File: rtl/state_dispatcher.sv
// Link-ownership dispatcher: a header byte selects a client channel, the next
// PAYLOAD_BYTES bytes form its payload, and the channel owns the link until it
// raises its ch_done bit. Optional inter-byte timeout: STATE_DISPATCHER_TIMEOUT_EN.
module state_dispatcher #(
  parameter int          N_CH          = 4,
  parameter int          PAYLOAD_BYTES = 2,
  parameter logic [7:0]  ID_SELF       = 8'h00,
  parameter logic [7:0]  BASE_ID       = 8'h10,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic [N_CH-1:0]            ch_done,
  output logic [7:0]                 active_id,
  output logic [N_CH-1:0]            ch_sel,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic [N_CH-1:0]            payload_valid,
  output logic                       state_change,
  output logic                       frame_err
);

  localparam int PW = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   buf_r;
  logic [2:0]      cnt_r;
  logic [N_CH-1:0] own_r;
`ifdef STATE_DISPATCHER_TIMEOUT_EN
  logic [15:0]     gap_r;
`endif

  logic [8:0]      offset_s;
  logic            in_range_s;
  logic [N_CH-1:0] one_hot_s;
  logic [PW-1:0]   shifted_s;
  logic            release_s;

  assign offset_s   = {1'b0, rx_data} - {1'b0, BASE_ID};
  assign in_range_s = (rx_data >= BASE_ID) && (offset_s < 9'(N_CH));
  assign one_hot_s  = N_CH'(1) << offset_s[3:0];
  // New byte enters at the top so the first byte ends up in bits [7:0].
  assign shifted_s  = (buf_r >> 8) | (PW'(rx_data) << (PW - 8));
  // ch_sel is zero outside ACTIVE, so only the owner's ch_done can release.
  assign release_s  = |(ch_done & ch_sel);

  // Dispatcher FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      buf_r         <= {PW{1'b0}};
      cnt_r         <= 3'd0;
      own_r         <= {N_CH{1'b0}};
`ifdef STATE_DISPATCHER_TIMEOUT_EN
      gap_r         <= 16'd0;
`endif
      active_id     <= ID_SELF;
      ch_sel        <= {N_CH{1'b0}};
      payload       <= {PW{1'b0}};
      payload_valid <= {N_CH{1'b0}};
      state_change  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      payload_valid <= {N_CH{1'b0}};
      state_change  <= 1'b0;
      frame_err     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_valid) begin
            if (in_range_s) begin
              state_r      <= PAYLOAD;
              active_id    <= rx_data;
              own_r        <= one_hot_s;
              cnt_r        <= 3'd0;
              state_change <= 1'b1;
`ifdef STATE_DISPATCHER_TIMEOUT_EN
              gap_r        <= 16'd0;
`endif
            end else if (rx_data != ID_SELF) begin
              frame_err <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            buf_r <= shifted_s;
`ifdef STATE_DISPATCHER_TIMEOUT_EN
            gap_r <= 16'd0;
`endif
            if (cnt_r == 3'(PAYLOAD_BYTES - 1)) begin
              state_r       <= ACTIVE;
              payload       <= shifted_s;
              payload_valid <= own_r;
              ch_sel        <= own_r;
              cnt_r         <= 3'd0;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
`ifdef STATE_DISPATCHER_TIMEOUT_EN
          end else if (gap_r == TIMEOUT_CYC - 16'd1) begin
            state_r      <= IDLE;
            active_id    <= ID_SELF;
            cnt_r        <= 3'd0;
            gap_r        <= 16'd0;
            state_change <= 1'b1;
            frame_err    <= 1'b1;
          end else begin
            gap_r <= gap_r + 16'd1;
`endif
          end else begin
            state_r <= PAYLOAD;
          end
        end
        ACTIVE: begin
          // Any rx byte here is dropped, including one coinciding with release.
          if (release_s) begin
            state_r      <= IDLE;
            active_id    <= ID_SELF;
            ch_sel       <= {N_CH{1'b0}};
            state_change <= 1'b1;
          end else begin
            state_r <= ACTIVE;
          end
        end
        default: begin
          state_r   <= IDLE;
          active_id <= ID_SELF;
          ch_sel    <= {N_CH{1'b0}};
          cnt_r     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_dispatcher.sv
// Directed scoreboard bench for state_dispatcher (default parameters, TIMEOUT_CYC=10).
module tb_state_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [3:0]  ch_done = 4'b0000;
  logic [7:0]  active_id;
  logic [3:0]  ch_sel;
  logic [15:0] payload;
  logic [3:0]  payload_valid;
  logic        state_change;
  logic        frame_err;

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  sel;
    logic [15:0] pl;
    logic [3:0]  pv;
    logic        sc;
    logic        fe;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  state_dispatcher #(.TIMEOUT_CYC(16'd10)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ch_done(ch_done), .active_id(active_id), .ch_sel(ch_sel),
    .payload(payload), .payload_valid(payload_valid),
    .state_change(state_change), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [7:0] id, logic [3:0] sel, logic [15:0] pl,
                              logic [3:0] pv, logic sc, logic fe);
    exp_t e;
    e.id = id; e.sel = sel; e.pl = pl; e.pv = pv; e.sc = sc; e.fe = fe;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, ":queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, ":active_id"},     {24'd0, active_id},     {24'd0, e.id});
      chk({tag, ":ch_sel"},        {28'd0, ch_sel},        {28'd0, e.sel});
      chk({tag, ":payload"},       {16'd0, payload},       {16'd0, e.pl});
      chk({tag, ":payload_valid"}, {28'd0, payload_valid}, {28'd0, e.pv});
      chk({tag, ":state_change"},  {31'd0, state_change},  {31'd0, e.sc});
      chk({tag, ":frame_err"},     {31'd0, frame_err},     {31'd0, e.fe});
    end
  endtask

  // One clock: drive inputs, push expectation, sample #1 after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [3:0] done, input exp_t e);
    rx_valid = v;
    rx_data  = d;
    ch_done  = done;
    q.push_back(e);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    compare(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk(8'h00, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0));
    compare("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Frame for channel 2
    step("hdr12",  1'b1, 8'h12, 4'b0000, mk(8'h12, 4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0));
    step("byteAB", 1'b1, 8'hAB, 4'b0000, mk(8'h12, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0));
    step("byteCD", 1'b1, 8'hCD, 4'b0000, mk(8'h12, 4'b0100, 16'hCDAB, 4'b0100, 1'b0, 1'b0));
    step("act_hold", 1'b0, 8'h00, 4'b0000, mk(8'h12, 4'b0100, 16'hCDAB, 4'b0000, 1'b0, 1'b0));
    step("act_rx11", 1'b1, 8'h11, 4'b0000, mk(8'h12, 4'b0100, 16'hCDAB, 4'b0000, 1'b0, 1'b0));
    step("act_rx55", 1'b1, 8'h55, 4'b0000, mk(8'h12, 4'b0100, 16'hCDAB, 4'b0000, 1'b0, 1'b0));
    step("done_other", 1'b0, 8'h00, 4'b0001, mk(8'h12, 4'b0100, 16'hCDAB, 4'b0000, 1'b0, 1'b0));
    step("done_own", 1'b0, 8'h00, 4'b0100, mk(8'h00, 4'b0000, 16'hCDAB, 4'b0000, 1'b1, 1'b0));
    step("post_release", 1'b0, 8'h00, 4'b0100, mk(8'h00, 4'b0000, 16'hCDAB, 4'b0000, 1'b0, 1'b0));

    // Rejected and self-addressed headers in IDLE
    step("bad_hdr20", 1'b1, 8'h20, 4'b0100, mk(8'h00, 4'b0000, 16'hCDAB, 4'b0000, 1'b0, 1'b1));
    step("self_hdr00", 1'b1, 8'h00, 4'b0100, mk(8'h00, 4'b0000, 16'hCDAB, 4'b0000, 1'b0, 1'b0));

    // ch_done held across a new frame releases on the first ACTIVE cycle
    step("held_hdr",  1'b1, 8'h12, 4'b0100, mk(8'h12, 4'b0000, 16'hCDAB, 4'b0000, 1'b1, 1'b0));
    step("held_b01",  1'b1, 8'h01, 4'b0100, mk(8'h12, 4'b0000, 16'hCDAB, 4'b0000, 1'b0, 1'b0));
    step("held_b02",  1'b1, 8'h02, 4'b0100, mk(8'h12, 4'b0100, 16'h0201, 4'b0100, 1'b0, 1'b0));
    step("held_rel",  1'b0, 8'h00, 4'b0100, mk(8'h00, 4'b0000, 16'h0201, 4'b0000, 1'b1, 1'b0));

    // Header byte coinciding with owner release is discarded
    step("c_hdr11", 1'b1, 8'h11, 4'b0000, mk(8'h11, 4'b0000, 16'h0201, 4'b0000, 1'b1, 1'b0));
    step("c_bAA",   1'b1, 8'hAA, 4'b0000, mk(8'h11, 4'b0000, 16'h0201, 4'b0000, 1'b0, 1'b0));
    step("c_bBB",   1'b1, 8'hBB, 4'b0000, mk(8'h11, 4'b0010, 16'hBBAA, 4'b0010, 1'b0, 1'b0));
    step("c_rel_rx", 1'b1, 8'h11, 4'b0010, mk(8'h00, 4'b0000, 16'hBBAA, 4'b0000, 1'b1, 1'b0));
    step("c_after", 1'b0, 8'h00, 4'b0000, mk(8'h00, 4'b0000, 16'hBBAA, 4'b0000, 1'b0, 1'b0));

    // Inter-byte gap in PAYLOAD
    step("t_hdr13", 1'b1, 8'h13, 4'b0000, mk(8'h13, 4'b0000, 16'hBBAA, 4'b0000, 1'b1, 1'b0));
    step("t_b01",   1'b1, 8'h01, 4'b0000, mk(8'h13, 4'b0000, 16'hBBAA, 4'b0000, 1'b0, 1'b0));
    for (int i = 0; i < 9; i++)
      step("t_gap", 1'b0, 8'h00, 4'b0000, mk(8'h13, 4'b0000, 16'hBBAA, 4'b0000, 1'b0, 1'b0));
`ifdef STATE_DISPATCHER_TIMEOUT_EN
    step("t_expire", 1'b0, 8'h00, 4'b0000, mk(8'h00, 4'b0000, 16'hBBAA, 4'b0000, 1'b1, 1'b1));
    step("t_late02", 1'b1, 8'h02, 4'b0000, mk(8'h00, 4'b0000, 16'hBBAA, 4'b0000, 1'b0, 1'b1));
`else
    step("t_gap10", 1'b0, 8'h00, 4'b0000, mk(8'h13, 4'b0000, 16'hBBAA, 4'b0000, 1'b0, 1'b0));
    step("t_late02", 1'b1, 8'h02, 4'b0000, mk(8'h13, 4'b1000, 16'h0201, 4'b1000, 1'b0, 1'b0));
    step("t_rel", 1'b0, 8'h00, 4'b1000, mk(8'h00, 4'b0000, 16'h0201, 4'b0000, 1'b1, 1'b0));
`endif

    // Asynchronous reset mid-frame, then a clean frame on channel 0
    step("r_hdr10", 1'b1, 8'h10, 4'b0000, mk(8'h10, 4'b0000, payload, 4'b0000, 1'b1, 1'b0));
    step("r_b77",   1'b1, 8'h77, 4'b0000, mk(8'h10, 4'b0000, payload, 4'b0000, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    q.push_back(mk(8'h00, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0));
    compare("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    step("r2_hdr", 1'b1, 8'h10, 4'b0000, mk(8'h10, 4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0));
    step("r2_b01", 1'b1, 8'h01, 4'b0000, mk(8'h10, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0));
    step("r2_b02", 1'b1, 8'h02, 4'b0000, mk(8'h10, 4'b0001, 16'h0201, 4'b0001, 1'b0, 1'b0));
    step("r2_rel", 1'b0, 8'h00, 4'b0001, mk(8'h00, 4'b0000, 16'h0201, 4'b0000, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
